// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/busy/done handshake.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiplies; divides stay iterative).
module alu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t            state;
    logic [CW-1:0]     counter;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mcand;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;

    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_result;

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3)
            3'd1:       begin sign_a = operand_a[XLEN-1]; sign_b = operand_b[XLEN-1]; end
            3'd2:       sign_a = operand_a[XLEN-1];
            3'd4, 3'd6: begin sign_a = operand_a[XLEN-1]; sign_b = operand_b[XLEN-1]; end
            default:    ;
        endcase
    end

    assign a_abs    = sign_a ? -operand_a : operand_a;
    assign b_abs    = sign_b ? -operand_b : operand_b;
    assign div_zero = (operand_b == '0);
    assign div_ovf  = (funct3 == 3'd4 || funct3 == 3'd6) && (operand_a == MIN_NEG)
                      && (operand_b == {XLEN{1'b1}});
    // funct3[1] selects the remainder; the overflow quotient equals operand_a itself
    assign special_result = funct3[1] ? (div_zero ? operand_a : '0)
                                      : (div_zero ? {XLEN{1'b1}} : operand_a);

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    // Multiply: low half holds the multiplier, high half accumulates; both shift right each step.
    // Divide: high half is the partial remainder, low half shifts the dividend out and quotient in.
    assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_next  = {mul_sum, prod[XLEN-1:1]};
    assign div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, mcand});
    assign div_diff  = div_shift[XLEN-1:0] - mcand;
    assign div_next  = {div_ge ? div_diff : div_shift[XLEN-1:0], prod[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_final;
    logic [XLEN-1:0]   rem_final;
    logic [XLEN-1:0]   final_result;

    assign prod_signed  = neg_q ? -prod : prod;
    assign quo_final    = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    assign rem_final    = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    assign final_result = op[2] ? (op[1] ? rem_final : quo_final)
                                : ((op[1:0] == 2'd0) ? prod_signed[XLEN-1:0]
                                                     : prod_signed[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag;
    logic [2*XLEN-1:0] fast_signed;
    logic [XLEN-1:0]   fast_result;

    assign fast_mag    = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
    assign fast_signed = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
    assign fast_result = (funct3 == 3'd0) ? fast_signed[XLEN-1:0] : fast_signed[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            counter <= '0;
            prod    <= '0;
            mcand   <= '0;
            op      <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            counter <= '0;
        end else begin
            case (state)
                // FIN behaves like IDLE so a new op can be accepted back-to-back
                IDLE, FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        op      <= funct3;
                        neg_q   <= sign_a ^ sign_b;
                        neg_r   <= sign_a;
                        counter <= '0;
                        if (funct3[2] && (div_zero || div_ovf)) begin
                            result <= special_result;
                            done   <= 1'b1;
                            state  <= FIN;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            result <= fast_result;
                            done   <= 1'b1;
                            state  <= FIN;
`endif
                        end else begin
                            busy  <= 1'b1;
                            state <= funct3[2] ? DIV : MUL;
                            prod  <= {{XLEN{1'b0}}, funct3[2] ? a_abs : b_abs};
                            mcand <= funct3[2] ? b_abs : a_abs;
                        end
                    end
                end
                MUL, DIV: begin
                    if (counter == LAST) begin
                        result <= final_result;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= FIN;
                    end else begin
                        prod    <= (state == MUL) ? mul_next : div_next;
                        counter <= counter + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed RV32M vectors, randomized ops vs a reference model,
// flush/start-ignore/back-to-back handshake scenarios and asynchronous reset.
module tb_alu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [31:0] last_res    = '0;

    alu_muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Architectural RV32M result computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0]        ua, ub, p;
        int                 ia, ib;
        logic [31:0]        r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sub = ub;
        ia  = a;
        ib  = b;
        r   = '0;
        case (f3)
            3'd0: begin p = ua * ub;  r = p[31:0];  end
            3'd1: begin p = sa * sb;  r = p[63:32]; end
            3'd2: begin p = sa * sub; r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges after the accepting edge until done is visible
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 0;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issues one op; inputs are scrambled after acceptance to prove they were latched
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cyc,
                         output logic busy_e0, output logic done_e0);
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        @(posedge clk); #1;
        busy_e0   = busy;
        done_e0   = done;
        cyc       = 0;
        start     = 1'b0;
        funct3    = 3'($urandom_range(0, 7));
        operand_a = $urandom;
        operand_b = $urandom;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = result;
    endtask

    task automatic test_reset();
        #12;
        check_count++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        else pass_count++;
        check_count++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
        else pass_count++;
        check_count++;
        if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", result);
        else pass_count++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                  32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                  32'h80000000, 32'h80000000};
        logic [31:0] bs  [12] = '{32'd6, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [12] = '{32'd42, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                  32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                                  32'h80000000, 32'h0};
        logic [31:0] res;
        int          cyc, lat;
        logic        busy_e0, done_e0;
        for (int i = 0; i < 12; i++) begin
            lat = exp_lat(f3s[i], as[i], bs[i]);
            do_op(f3s[i], as[i], bs[i], res, cyc, busy_e0, done_e0);
            check_count++;
            if (res !== exp[i]) $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, exp[i]);
            else pass_count++;
            check_count++;
            if (cyc != lat) $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, cyc, lat);
            else pass_count++;
            check_count++;
            if (busy_e0 !== (lat > 0)) $display("[TB] FAIL directed_busy[%0d]: got %b expected %b", i, busy_e0, lat > 0);
            else pass_count++;
            last_res = exp[i];
            @(posedge clk); #1;
            check_count++;
            if (done !== 1'b0) $display("[TB] FAIL directed_done_pulse[%0d]: got %b expected 0", i, done);
            else pass_count++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int          cyc, lat;
        logic        busy_e0, done_e0;
        for (int i = 0; i < 30; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = rand_operand();
            b   = rand_operand();
            exp = ref_model(f3, a, b);
            lat = exp_lat(f3, a, b);
            do_op(f3, a, b, res, cyc, busy_e0, done_e0);
            check_count++;
            if (res !== exp) $display("[TB] FAIL random_result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp);
            else pass_count++;
            check_count++;
            if (cyc != lat) $display("[TB] FAIL random_latency f3=%0d: got %0d expected %0d", f3, cyc, lat);
            else pass_count++;
            last_res = exp;
            @(posedge clk); #1;
            check_count++;
            if (done !== 1'b0) $display("[TB] FAIL random_done_pulse: got %b expected 0", done);
            else pass_count++;
        end
    endtask

    task automatic test_flush();
        logic done_seen;
        start     = 1'b1;
        funct3    = 3'd4;
        operand_a = 32'd123456;
        operand_b = 32'd789;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_count++;
        if (busy !== 1'b0) $display("[TB] FAIL flush_busy: got %b expected 0", busy);
        else pass_count++;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        check_count++;
        if (done_seen !== 1'b0) $display("[TB] FAIL flush_no_done: got %b expected 0", done_seen);
        else pass_count++;
        check_count++;
        if (result !== last_res) $display("[TB] FAIL flush_result_kept: got %h expected %h", result, last_res);
        else pass_count++;

        // Start and flush together: flush wins, nothing is accepted
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'd5;
        operand_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check_count++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL start_flush_ignored: got busy=%b done=%b expected busy=0 done=0", busy, done);
        else pass_count++;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        check_count++;
        if (done_seen !== 1'b0) $display("[TB] FAIL start_flush_no_done: got %b expected 0", done_seen);
        else pass_count++;
    endtask

    task automatic test_busy_ignore();
        int cyc;
        start     = 1'b1;
        funct3    = 3'd5;
        operand_a = 32'd100;
        operand_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start     = 1'b1;
        funct3    = 3'd0;
        operand_a = 32'd5;
        operand_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 4;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_count++;
        if (result !== 32'd14) $display("[TB] FAIL busy_ignore_result: got %h expected 0000000e", result);
        else pass_count++;
        check_count++;
        if (cyc != 33) $display("[TB] FAIL busy_ignore_latency: got %0d expected 33", cyc);
        else pass_count++;
        last_res = 32'd14;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, res;
        int          cyc;
        logic        busy_e0, done_e0;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom & 32'h7FFFFFFF;
        b2 = $urandom | 32'h1;
        do_op(3'd0, a1, b1, res, cyc, busy_e0, done_e0);
        check_count++;
        if (res !== a1 * b1) $display("[TB] FAIL b2b_first: got %h expected %h", res, a1 * b1);
        else pass_count++;
        do_op(3'd4, a2, b2, res, cyc, busy_e0, done_e0);
        check_count++;
        if (done_e0 !== 1'b0 || busy_e0 !== 1'b1)
            $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy_e0, done_e0);
        else pass_count++;
        check_count++;
        if (res !== ref_model(3'd4, a2, b2)) $display("[TB] FAIL b2b_second: got %h expected %h", res, ref_model(3'd4, a2, b2));
        else pass_count++;
        check_count++;
        if (cyc != 33) $display("[TB] FAIL b2b_second_latency: got %0d expected 33", cyc);
        else pass_count++;
        do_op(3'd7, a2, 32'd0, res, cyc, busy_e0, done_e0);
        check_count++;
        if (res !== a2 || cyc != 0)
            $display("[TB] FAIL b2b_special: got %h after %0d edges expected %h after 0", res, cyc, a2);
        else pass_count++;
        last_res = a2;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        start     = 1'b1;
        funct3    = 3'd4;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_count++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0)
            $display("[TB] FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
        else pass_count++;
        #1 rst = 1'b0;
        last_res = '0;
        @(posedge clk); #1;
        check_count++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        else pass_count++;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        funct3    = 3'd0;
        operand_a = '0;
        operand_b = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
